// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizes RX, detects the start edge, samples each bit
// at mid-period using the shared baud table and strobes good bytes or framing errors.
module uart_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       uart_en,
    input  logic [2:0] baud_rx_sel,
    input  logic       RX,
    output logic [7:0] data_out,
    output logic       rx_done,
    output logic       frame_err,
    output logic       rx_busy
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    function automatic logic [13:0] bit_count(input logic [2:0] sel);
        case (sel)
            3'b000:  return 14'd10416;
            3'b001:  return 14'd5208;
            3'b010:  return 14'd2604;
            3'b011:  return 14'd1736;
            3'b100:  return 14'd868;
            3'b101:  return 14'd434;
            3'b110:  return 14'd217;
            default: return 14'd108;
        endcase
    endfunction

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   rx_prev_q;
    logic                   rx_s;
    logic [13:0]            baud_cnt_q, baud_cnt_d;
    logic [2:0]             data_cnt_q, data_cnt_d;
    logic [2:0]             sel_q, sel_d;
    logic [7:0]             shift_q, shift_d;
    logic [7:0]             data_out_q, data_out_d;
    logic                   done_q, done_d;
    logic                   ferr_q, ferr_d;
    logic [13:0]            n_bits;
    logic [13:0]            half_bits;

    assign rx_s      = sync_q[SYNC_STAGES-1];
    assign sync_d    = {sync_q[SYNC_STAGES-2:0], RX};
    assign n_bits    = bit_count(sel_q);
    assign half_bits = n_bits >> 1;

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        data_cnt_d = data_cnt_q;
        sel_d      = sel_q;
        shift_d    = shift_q;
        data_out_d = data_out_q;
        done_d     = 1'b0;
        ferr_d     = 1'b0;

        if (!uart_en) begin
            state_d    = IDLE;
            baud_cnt_d = '0;
            data_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    baud_cnt_d = '0;
                    // Edge-triggered, so a line stuck low cannot start a new frame.
                    if (rx_prev_q && !rx_s) begin
                        state_d = START;
                        sel_d   = baud_rx_sel;
                    end
                end
                START: begin
                    if (baud_cnt_q == half_bits) begin
                        baud_cnt_d = '0;
                        data_cnt_d = '0;
                        state_d    = rx_s ? IDLE : DATA;
                    end else begin
                        baud_cnt_d = baud_cnt_q + 14'd1;
                    end
                end
                DATA: begin
                    if (baud_cnt_q == n_bits) begin
                        baud_cnt_d          = '0;
                        shift_d[data_cnt_q] = rx_s;
                        if (data_cnt_q == 3'd7) begin
                            state_d = STOP;
                        end else begin
                            data_cnt_d = data_cnt_q + 3'd1;
                        end
                    end else begin
                        baud_cnt_d = baud_cnt_q + 14'd1;
                    end
                end
                STOP: begin
                    if (baud_cnt_q == n_bits) begin
                        baud_cnt_d = '0;
                        state_d    = IDLE;
                        if (rx_s) begin
                            data_out_d = shift_q;
                            done_d     = 1'b1;
                        end else begin
                            ferr_d = 1'b1;
                        end
                    end else begin
                        baud_cnt_d = baud_cnt_q + 14'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            sync_q     <= '1;
            rx_prev_q  <= 1'b1;
            baud_cnt_q <= '0;
            data_cnt_q <= '0;
            sel_q      <= '0;
            shift_q    <= '0;
            data_out_q <= '0;
            done_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            rx_prev_q  <= rx_s;
            baud_cnt_q <= baud_cnt_d;
            data_cnt_q <= data_cnt_d;
            sel_q      <= sel_d;
            shift_q    <= shift_d;
            data_out_q <= data_out_d;
            done_q     <= done_d;
            ferr_q     <= ferr_d;
        end
    end

    assign data_out  = data_out_q;
    assign rx_done   = done_q;
    assign frame_err = ferr_q;
    assign rx_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: a behavioural serial driver plus a frame-level
// model (queue of expected bytes, counts of expected strobes) checked with assertions.
module tb_uart_rx;

    localparam int SYNC_STAGES = 2;

    logic       clock;
    logic       resetn;
    logic       uart_en;
    logic [2:0] baud_rx_sel;
    logic       RX;
    logic [7:0] data_out;
    logic       rx_done;
    logic       frame_err;
    logic       rx_busy;

    uart_rx #(.SYNC_STAGES(SYNC_STAGES)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .uart_en     (uart_en),
        .baud_rx_sel (baud_rx_sel),
        .RX          (RX),
        .data_out    (data_out),
        .rx_done     (rx_done),
        .frame_err   (frame_err),
        .rx_busy     (rx_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    // Observed side: counted on the falling edge, away from the active edge.
    int         cyc = 0;
    int         done_cnt = 0;
    int         err_cnt = 0;
    int         bad_pulse_cnt = 0;
    int         last_done_cyc = 0;
    logic       prev_done = 1'b0;
    logic       prev_ferr = 1'b0;
    logic [7:0] got_q[$];

    always @(posedge clock) cyc++;

    always @(negedge clock) begin
        if (rx_done) begin
            done_cnt++;
            got_q.push_back(data_out);
            last_done_cyc = cyc;
        end
        if (frame_err) err_cnt++;
        if ((rx_done && frame_err) || (rx_done && prev_done) || (frame_err && prev_ferr))
            bad_pulse_cnt++;
        prev_done = rx_done;
        prev_ferr = frame_err;
    end

    // Reference model: what a correct receiver must have reported so far.
    logic [7:0] exp_q[$];
    int         exp_done = 0;
    int         exp_err = 0;
    logic [7:0] exp_last = 8'h00;
    int         rd_idx = 0;

    function automatic int n_of(input logic [2:0] sel);
        int tbl[8] = '{10416, 5208, 2604, 1736, 868, 434, 217, 108};
        return tbl[sel];
    endfunction

    task automatic model_frame(input logic [7:0] b, input logic stop);
        if (stop) begin
            exp_q.push_back(b);
            exp_done++;
            exp_last = b;
        end else begin
            exp_err++;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_rx(input string tag);
        check({tag, "/done_cnt"}, 32'(done_cnt), 32'(exp_done));
        check({tag, "/ferr_cnt"}, 32'(err_cnt), 32'(exp_err));
        check({tag, "/pulse_shape"}, 32'(bad_pulse_cnt), 32'd0);
        while (rd_idx < got_q.size() && rd_idx < exp_q.size()) begin
            check({tag, "/byte"}, 32'(got_q[rd_idx]), 32'(exp_q[rd_idx]));
            rd_idx++;
        end
        check({tag, "/data_out"}, 32'(data_out), 32'(exp_last));
    endtask

    // Edge-to-strobe latency must match the documented formula within one cycle.
    task automatic check_lat(input string tag, input int t0, input int n);
        int lat;
        int exp_lat;
        lat     = last_done_cyc - t0;
        exp_lat = SYNC_STAGES + 1 + (n / 2) + 1 + 9 * (n + 1);
        check({tag, "/latency"}, 32'((lat >= exp_lat - 1 && lat <= exp_lat + 1) ? exp_lat : lat),
              32'(exp_lat));
    endtask

    // Behavioural transmitter: each bit held n+1 cycles, entered and left on a falling edge.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int n,
                              output int t0, output logic busy_mid);
        logic bit_v;
        t0       = cyc;
        busy_mid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bit_v = (i == 0) ? 1'b0 : (i == 9) ? stop : b[i-1];
            RX = bit_v;
            for (int j = 0; j <= n; j++) begin
                if (i == 5 && j == 0) busy_mid = rx_busy;
                @(negedge clock);
            end
        end
    endtask

    initial begin
        #990000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

    initial begin
        int         t0;
        logic       bm;
        logic [7:0] b;
        logic       stop;
        logic [2:0] sel;
        logic [7:0] fixed_bytes[3];

        resetn      = 1'b0;
        uart_en     = 1'b0;
        RX          = 1'b1;
        baud_rx_sel = 3'b111;
        repeat (3) @(negedge clock);
        check("reset/data_out", 32'(data_out), 32'h00);
        check("reset/rx_done", 32'(rx_done), 32'd0);
        check("reset/frame_err", 32'(frame_err), 32'd0);
        check("reset/rx_busy", 32'(rx_busy), 32'd0);
        resetn  = 1'b1;
        uart_en = 1'b1;
        repeat (5) @(negedge clock);

        // Good frame at the fastest rate.
        send_frame(8'hA5, 1'b1, n_of(3'b111), t0, bm);
        model_frame(8'hA5, 1'b1);
        check_rx("a5");
        check_lat("a5", t0, n_of(3'b111));
        check("a5/busy_mid", 32'(bm), 32'd1);
        check("a5/busy_after", 32'(rx_busy), 32'd0);

        // Short low glitch: START rejects at the half-bit sample.
        RX = 1'b0;
        repeat (20) @(negedge clock);
        RX = 1'b1;
        repeat (10) @(negedge clock);
        check("glitch/busy_in_start", 32'(rx_busy), 32'd1);
        repeat (50) @(negedge clock);
        check("glitch/busy_after", 32'(rx_busy), 32'd0);
        check_rx("glitch");

        // Stop bit driven low: framing error, data_out held.
        send_frame(8'h3C, 1'b0, n_of(3'b111), t0, bm);
        model_frame(8'h3C, 1'b0);
        RX = 1'b1;
        repeat (20) @(negedge clock);
        check_rx("ferr");

        // Back-to-back frames with no idle gap.
        baud_rx_sel = 3'b100;
        send_frame(8'h00, 1'b1, n_of(3'b100), t0, bm);
        model_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1, n_of(3'b100), t0, bm);
        model_frame(8'hFF, 1'b1);
        repeat (4) @(negedge clock);
        check_rx("b2b");

        // Enable dropped during data bit 3: abort without strobes.
        baud_rx_sel = 3'b111;
        fork
            send_frame(8'h96, 1'b1, n_of(3'b111), t0, bm);
            begin
                repeat (4 * (n_of(3'b111) + 1) + n_of(3'b111) / 2) @(negedge clock);
                check("abort/busy_before", 32'(rx_busy), 32'd1);
                uart_en = 1'b0;
                @(negedge clock);
                check("abort/busy_after", 32'(rx_busy), 32'd0);
            end
        join
        repeat (4) @(negedge clock);
        check_rx("abort");
        uart_en = 1'b1;
        repeat (3) @(negedge clock);
        send_frame(8'h5A, 1'b1, n_of(3'b111), t0, bm);
        model_frame(8'h5A, 1'b1);
        check_rx("reenable");
        check_lat("reenable", t0, n_of(3'b111));

        // Loopback-style bytes at sel=110.
        fixed_bytes = '{8'h00, 8'h55, 8'hFF};
        baud_rx_sel = 3'b110;
        for (int k = 0; k < 3; k++) begin
            send_frame(fixed_bytes[k], 1'b1, n_of(3'b110), t0, bm);
            model_frame(fixed_bytes[k], 1'b1);
            check_lat("sel110", t0, n_of(3'b110));
        end
        check_rx("sel110");

        // Asynchronous reset mid-frame returns all outputs to reset values at once.
        fork
            send_frame(8'hC3, 1'b1, n_of(3'b110), t0, bm);
            begin
                repeat (3 * (n_of(3'b110) + 1)) @(negedge clock);
                #2 resetn = 1'b0;
                #1;
                check("rst_mid/data_out", 32'(data_out), 32'h00);
                check("rst_mid/rx_busy", 32'(rx_busy), 32'd0);
                check("rst_mid/rx_done", 32'(rx_done), 32'd0);
                check("rst_mid/frame_err", 32'(frame_err), 32'd0);
            end
        join
        exp_last = 8'h00;
        @(negedge clock);
        resetn = 1'b1;
        repeat (5) @(negedge clock);
        check_rx("rst_mid");

        // Randomized frames; the select input is scrambled mid-frame to show it is latched.
        for (int k = 0; k < 6; k++) begin
            sel  = 3'($urandom_range(5, 7));
            b    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            baud_rx_sel = sel;
            fork
                send_frame(b, stop, n_of(sel), t0, bm);
                begin
                    repeat (10) @(negedge clock);
                    baud_rx_sel = 3'($urandom);
                end
            join
            baud_rx_sel = sel;
            model_frame(b, stop);
            if (stop) begin
                check_lat("rand", t0, n_of(sel));
                repeat ($urandom_range(0, 5)) @(negedge clock);
            end else begin
                RX = 1'b1;
                repeat (20) @(negedge clock);
            end
            check_rx("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
